ddr2_port_arbiter: RTL and testbench
====================================

DDR2_PORT_ARBITER -- requirements
Module: ddr2_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 31, width of the DDR2 controller application address.
REQ-002 Parameter DATA_W, default 128, width of the controller write and read data FIFO word.
REQ-003 Parameter TAG_DEPTH, default 8, maximum number of outstanding read bursts.
REQ-004 Parameter VID_MAX, default 4, number of consecutive video grants allowed while the host waits.
REQ-005 Ports, clock and reset first, as name, direction, width and meaning:
- clk, in, 1, single clock for the whole block.
- rst, in, 1, reset; asynchronous and active-low.
- phy_init_done, in, 1, DDR2 calibration complete.
- vid_req, in, 1, video read request.
- vid_addr, in, ADDR_W, video read address.
- vid_ack, out, 1, one-cycle pulse when the video command is issued.
- vid_rd_valid, out, 1, video read data valid.
- host_req, in, 1, host (UART bridge) request.
- host_we, in, 1, host write enable.
- host_addr, in, ADDR_W, host address.
- host_wdata, in, 2*DATA_W, host write burst (low word first).
- host_ack, out, 1, one-cycle pulse when the host command is issued.
- host_rd_valid, out, 1, host read data valid.
- rd_data, out, DATA_W, read data shared by both requesters.
- app_af_cmd, out, 3, command: 000 write, 001 read.
- app_af_addr, out, ADDR_W, command address.
- app_af_wren, out, 1, command FIFO write.
- app_af_afull, in, 1, command FIFO almost full.
- app_wdf_data, out, DATA_W, write data.
- app_wdf_wren, out, 1, write data FIFO write.
- app_wdf_mask_data, out, DATA_W/8, write mask.
- app_wdf_afull, in, 1, write FIFO almost full.
- rd_data_valid, in, 1, controller read beat valid.
- rd_data_fifo_out, in, DATA_W, controller read beat.

Function
REQ-006 The FSM SHALL have the states IDLE, WR_D0, WR_D1 and CMD, and no request is granted while phy_init_done=0.
REQ-007 In IDLE with at least one eligible request, the arbiter SHALL select video over host unless host_req has been pending and vid_cnt==VID_MAX; in that case host wins and vid_cnt clears.
REQ-008 vid_cnt SHALL increment on each video grant while host_req=1, SHALL clear on each host grant or when host_req=0, and SHALL saturate at VID_MAX.
REQ-009 A read request SHALL be eligible only if the tag FIFO is not full and app_af_afull=0; a write request SHALL be eligible only if app_af_afull=0 and app_wdf_afull=0.
REQ-010 A host write SHALL proceed as follows:
- Capture host_addr and host_wdata.
- WR_D0 writes the low word (app_wdf_wren=1).
- WR_D1 writes the high word.
- CMD issues cmd 000.
- Each step stalls while app_wdf_afull or app_af_afull (for CMD) is 1.
REQ-011 A read SHALL go IDLE->CMD, issue cmd 001 and push a one-bit owner tag (0 video, 1 host) in the same cycle as app_af_wren.
REQ-012 The ack SHALL pulse in the CMD cycle that asserts app_af_wren, and the FSM SHALL return to IDLE on the next cycle; minimum grant-to-command latency is 1 cycle for reads and 3 cycles for writes.
REQ-013 app_wdf_mask_data SHALL be 0 (no masking) on every write beat.
REQ-014 Each rd_data_valid beat SHALL be forwarded combinationally: rd_data=rd_data_fifo_out, and vid_rd_valid or host_rd_valid follows the head tag.
REQ-015 The tag SHALL pop on the second beat of each burst, using a 1-bit beat toggle.
REQ-016 A simultaneous tag push and pop SHALL leave the occupancy unchanged.
REQ-017 rd_data_valid with an empty tag FIFO SHALL be dropped, and both valid outputs stay 0.
REQ-018 Requesters SHALL hold req and its operands until ack; a deassertion before ack is ignored once the grant is latched.

Reset
REQ-019 While rst=0 the block SHALL be reset as follows:
- FSM goes to IDLE.
- vid_cnt, the tag FIFO and the beat toggle clear.
- All outputs are 0, including app_af_cmd=000 and rd_data=0.
REQ-020 Reset asserted mid-write SHALL abandon the burst with no further wren; reset SHALL release synchronously to clk through a two-flop synchronizer on the deassertion edge.

Structure
REQ-021 State encodings, command codes (CMD_WR=3'b000, CMD_RD=3'b001) and tag values SHALL live in the shared package ddr2_arb_pkg.
REQ-022 The tag FIFO SHALL be the sub-module rd_tag_fifo, parameterised by TAG_DEPTH, with 1-bit data and full/empty flags.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset with phy_init_done=0, then vid_req=1 -> no app_af_wren until phy_init_done=1; then cmd 001 at vid_addr and a vid_ack pulse.
- Host write to address 0x100 with host_wdata={B,A} -> wdf beats A then B, then cmd 000 at 0x100 and host_ack in the 3rd cycle after grant.
- vid_req and host_req held continuously with VID_MAX=4 -> grant pattern V,V,V,V,H repeating.
- 8 video reads with rd_data_valid held off -> the 9th request is not granted; after one 2-beat return it is granted, and vid_rd_valid pulses exactly twice.
- Interleaved host read then video read -> the first 2 beats assert host_rd_valid and the next 2 assert vid_rd_valid.
- Reset asserted between WR_D0 and WR_D1 -> no further app_wdf_wren or app_af_wren, and all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/ddr2_arb_pkg.sv
// Shared encodings for the DDR2 two-port arbiter: FSM states, controller command codes, read-owner tags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_D0 = 2'd1,
        WR_D1 = 2'd2,
        CMD   = 2'd3
    } arb_state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // Owner tag carried with each outstanding read burst.
    localparam logic TAG_VID  = 1'b0;
    localparam logic TAG_HOST = 1'b1;

endpackage

// File: rtl/ddr2_port_arbiter_if.sv
// Bundle of requester, command-FIFO, write-FIFO and read-return signals around the arbiter.
// Latency: n/a (wires only); master = arbiter side, slave = requesters plus DDR2 controller.
// Backpressure: app_af_afull / app_wdf_afull flow from slave to master; req/ack handshake per requester.
interface ddr2_port_arbiter_if #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 128
);
    logic                  phy_init_done;
    logic                  vid_req;
    logic [ADDR_W-1:0]     vid_addr;
    logic                  vid_ack;
    logic                  vid_rd_valid;
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_W-1:0]     host_addr;
    logic [2*DATA_W-1:0]   host_wdata;
    logic                  host_ack;
    logic                  host_rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic [2:0]            app_af_cmd;
    logic [ADDR_W-1:0]     app_af_addr;
    logic                  app_af_wren;
    logic                  app_af_afull;
    logic [DATA_W-1:0]     app_wdf_data;
    logic                  app_wdf_wren;
    logic [DATA_W/8-1:0]   app_wdf_mask_data;
    logic                  app_wdf_afull;
    logic                  rd_data_valid;
    logic [DATA_W-1:0]     rd_data_fifo_out;

    modport master (
        input  phy_init_done, vid_req, vid_addr, host_req, host_we, host_addr, host_wdata,
               app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
        output vid_ack, vid_rd_valid, host_ack, host_rd_valid, rd_data,
               app_af_cmd, app_af_addr, app_af_wren, app_wdf_data, app_wdf_wren, app_wdf_mask_data
    );

    modport slave (
        output phy_init_done, vid_req, vid_addr, host_req, host_we, host_addr, host_wdata,
               app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
        input  vid_ack, vid_rd_valid, host_ack, host_rd_valid, rd_data,
               app_af_cmd, app_af_addr, app_af_wren, app_wdf_data, app_wdf_wren, app_wdf_mask_data
    );

endinterface

// File: rtl/rd_tag_fifo.sv
// Owner-tag FIFO for outstanding read bursts; ports: push/push_dat in, pop in, head/full/empty out.
// Latency: head is the oldest tag, visible combinationally; push lands after one clock.
// Backpressure: full blocks push unless a pop happens in the same cycle; pop on empty is ignored.
module rd_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_dat,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok, pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            // Push and pop together leave occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Arbitrates video reads and host reads/writes onto one DDR2 controller; routes read beats back by owner tag.
// Latency: grant->command 1 cycle for reads, 3 cycles for writes (two data beats first); read return is combinational.
// Backpressure: app_af_afull / app_wdf_afull stall the FSM in place; reads wait while the tag FIFO is full.
module ddr2_port_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int ADDR_W    = 31,
    parameter int DATA_W    = 128,
    parameter int TAG_DEPTH = 8,
    parameter int VID_MAX   = 4
) (
    input  logic                clk,
    input  logic                rst,
    ddr2_port_arbiter_if.master bus
);
    localparam int                CNT_W     = $clog2(VID_MAX + 1);
    localparam logic [CNT_W-1:0]  VID_MAX_C = CNT_W'(VID_MAX);

    // Assert asynchronously, release two clocks after rst rises.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    arb_state_t           state, state_nxt;
    logic                 cmd_is_rd;
    logic                 owner;
    logic [ADDR_W-1:0]    lat_addr;
    logic [2*DATA_W-1:0]  lat_wdata;
    logic [CNT_W-1:0]     vid_cnt;

    logic tag_full, tag_empty, tag_head, tag_push, tag_pop;
    logic beat;
    logic rd_ok, wr_ok, vid_elig, host_elig, host_grant, vid_grant;
    logic af_wren, wdf_wren;
    logic [DATA_W-1:0] wdf_data;
    logic rd_fwd;

    assign rd_ok      = !tag_full && !bus.app_af_afull;
    assign wr_ok      = !bus.app_af_afull && !bus.app_wdf_afull;
    assign vid_elig   = bus.phy_init_done && bus.vid_req && rd_ok;
    assign host_elig  = bus.phy_init_done && bus.host_req && (bus.host_we ? wr_ok : rd_ok);
    // Video has priority until it has taken VID_MAX grants back-to-back while the host waited.
    assign host_grant = (state == IDLE) && host_elig && (!vid_elig || vid_cnt == VID_MAX_C);
    assign vid_grant  = (state == IDLE) && vid_elig && !host_grant;

    always_comb begin
        state_nxt = state;
        af_wren   = 1'b0;
        wdf_wren  = 1'b0;
        wdf_data  = '0;
        case (state)
            IDLE: begin
                if (host_grant)     state_nxt = bus.host_we ? WR_D0 : CMD;
                else if (vid_grant) state_nxt = CMD;
            end
            WR_D0: begin
                wdf_data = lat_wdata[DATA_W-1:0];
                if (!bus.app_wdf_afull) begin
                    wdf_wren  = 1'b1;
                    state_nxt = WR_D1;
                end
            end
            WR_D1: begin
                wdf_data = lat_wdata[2*DATA_W-1:DATA_W];
                if (!bus.app_wdf_afull) begin
                    wdf_wren  = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (!bus.app_af_afull) begin
                    af_wren   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_is_rd <= 1'b0;
            owner     <= TAG_VID;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            // Operands are captured at grant, so a later req drop cannot corrupt the command.
            if (host_grant) begin
                owner     <= TAG_HOST;
                cmd_is_rd <= !bus.host_we;
                lat_addr  <= bus.host_addr;
                lat_wdata <= bus.host_wdata;
            end else if (vid_grant) begin
                owner     <= TAG_VID;
                cmd_is_rd <= 1'b1;
                lat_addr  <= bus.vid_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_cnt <= '0;
        end else if (host_grant || !bus.host_req) begin
            vid_cnt <= '0;
        end else if (vid_grant && vid_cnt != VID_MAX_C) begin
            vid_cnt <= vid_cnt + 1'b1;
        end
    end

    assign bus.app_af_wren       = af_wren;
    assign bus.app_af_cmd        = (state == CMD && cmd_is_rd) ? CMD_RD : CMD_WR;
    assign bus.app_af_addr       = (state == CMD) ? lat_addr : '0;
    assign bus.vid_ack           = af_wren && (owner == TAG_VID);
    assign bus.host_ack          = af_wren && (owner == TAG_HOST);
    assign bus.app_wdf_wren      = wdf_wren;
    assign bus.app_wdf_data      = wdf_data;
    assign bus.app_wdf_mask_data = '0;

    // Beats arriving with no outstanding tag are dropped; the toggle counts only forwarded beats.
    assign rd_fwd            = bus.rd_data_valid && !tag_empty;
    assign bus.rd_data       = rd_fwd ? bus.rd_data_fifo_out : '0;
    assign bus.vid_rd_valid  = rd_fwd && (tag_head == TAG_VID);
    assign bus.host_rd_valid = rd_fwd && (tag_head == TAG_HOST);

    assign tag_push = af_wren && cmd_is_rd;
    assign tag_pop  = rd_fwd && beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      beat <= 1'b0;
        else if (rd_fwd) beat <= ~beat;
    end

    rd_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tag_push),
        .push_dat (owner),
        .pop      (tag_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Self-checking bench for ddr2_port_arbiter: directed sequences, eligibility and read-return tables.
// Latency: n/a.
// Backpressure: exercised through app_af_afull / app_wdf_afull and a full tag FIFO.
module tb_ddr2_port_arbiter;
    import ddr2_arb_pkg::*;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 128;

    localparam logic [ADDR_W-1:0] VA = 31'h0000_2340;
    localparam logic [ADDR_W-1:0] HA = 31'h0000_0100;
    localparam logic [DATA_W-1:0] WA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [DATA_W-1:0] WB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [DATA_W-1:0] D0 = 128'h1000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [DATA_W-1:0] D1 = 128'h2000_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [DATA_W-1:0] D2 = 128'h3000_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [DATA_W-1:0] D3 = 128'h4000_0000_0000_0000_0000_0000_0000_0004;
    localparam logic [DATA_W-1:0] D4 = 128'h5000_0000_0000_0000_0000_0000_0000_0005;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr2_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr2_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(8), .VID_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cmd_seen = 0;
    int vid_rv_cnt = 0;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic              host;
    } exp_cmd_t;
    exp_cmd_t exp_q[$];

    typedef struct packed {
        logic phy, v, h, we, af, wdf;
        logic [2:0] exp;   // {vid_ack, host_ack, app_wdf_wren} one cycle after the grant cycle
    } elig_t;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] dat;
        logic              exp_v;
        logic              exp_h;
        logic [DATA_W-1:0] exp_d;
    } beat_t;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.vid_req          = 1'b0;
        bus.vid_addr         = VA;
        bus.host_req         = 1'b0;
        bus.host_we          = 1'b0;
        bus.host_addr        = HA;
        bus.host_wdata       = {WB, WA};
        bus.app_af_afull     = 1'b0;
        bus.app_wdf_afull    = 1'b0;
        bus.rd_data_valid    = 1'b0;
        bus.rd_data_fifo_out = '0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctrl"}, {bus.app_af_wren, bus.app_wdf_wren, bus.vid_ack, bus.host_ack,
                            bus.vid_rd_valid, bus.host_rd_valid, bus.app_af_cmd}, 0);
        chk({nm, "_addr"}, bus.app_af_addr, 0);
        chk({nm, "_wdata"}, bus.app_wdf_data, 0);
        chk({nm, "_mask"}, bus.app_wdf_mask_data, 0);
        chk({nm, "_rdata"}, bus.rd_data, 0);
    endtask

    task automatic do_reset(input logic phy);
        chk("sb_leftover", exp_q.size(), 0);
        exp_q.delete();
        clear_inputs();
        bus.phy_init_done = phy;
        rst = 1'b0;
        // Read beat offered during reset must not leak out.
        bus.rd_data_valid    = 1'b1;
        bus.rd_data_fifo_out = D4;
        #1;
        check_all_zero("rst");
        repeat (2) step();
        bus.rd_data_valid = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        cmd_seen   = 0;
        vid_rv_cnt = 0;
    endtask

    task automatic wait_cmds(input int n, input string nm);
        int cyc = 0;
        while (cmd_seen < n && cyc < 300) begin
            step();
            cyc++;
        end
        chk(nm, cmd_seen, n);
    endtask

    // Command scoreboard: every app_af_wren must match the oldest expected command.
    always @(negedge clk) begin
        if (bus.vid_rd_valid) vid_rv_cnt++;
        if (bus.app_af_wren) begin
            cmd_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: cmd %0h addr %0h with nothing expected",
                         bus.app_af_cmd, bus.app_af_addr);
            end else begin
                exp_cmd_t e;
                e = exp_q.pop_front();
                chk("sb_cmd", bus.app_af_cmd, e.cmd);
                chk("sb_addr", bus.app_af_addr, e.addr);
                chk("sb_owner", {bus.host_ack, bus.vid_ack}, e.host ? 2'b10 : 2'b01);
            end
        end
    end

    initial begin
        elig_t el[8];
        beat_t rt[6];

        el[0] = '{phy:0, v:1, h:0, we:0, af:0, wdf:0, exp:3'b000};
        el[1] = '{phy:1, v:1, h:1, we:0, af:0, wdf:0, exp:3'b100};
        el[2] = '{phy:1, v:0, h:1, we:0, af:0, wdf:0, exp:3'b010};
        el[3] = '{phy:1, v:0, h:1, we:1, af:0, wdf:0, exp:3'b001};
        el[4] = '{phy:1, v:1, h:0, we:0, af:1, wdf:0, exp:3'b000};
        el[5] = '{phy:1, v:0, h:1, we:1, af:0, wdf:1, exp:3'b000};
        el[6] = '{phy:1, v:1, h:1, we:1, af:0, wdf:1, exp:3'b100};
        el[7] = '{phy:1, v:0, h:1, we:0, af:0, wdf:1, exp:3'b010};

        rt[0] = '{vld:1, dat:D0, exp_v:0, exp_h:1, exp_d:D0};
        rt[1] = '{vld:1, dat:D1, exp_v:0, exp_h:1, exp_d:D1};
        rt[2] = '{vld:0, dat:D2, exp_v:0, exp_h:0, exp_d:'0};
        rt[3] = '{vld:1, dat:D2, exp_v:1, exp_h:0, exp_d:D2};
        rt[4] = '{vld:1, dat:D3, exp_v:1, exp_h:0, exp_d:D3};
        rt[5] = '{vld:1, dat:D4, exp_v:0, exp_h:0, exp_d:'0};

        clear_inputs();
        bus.phy_init_done = 1'b0;
        #2;

        // 1: no grant before calibration, then a video read.
        do_reset(1'b0);
        bus.vid_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_cmd_before_init", bus.app_af_wren, 0);
        end
        exp_q.push_back('{cmd:CMD_RD, addr:VA, host:1'b0});
        bus.phy_init_done = 1'b1;
        step();
        chk("vid_rd_cmd", {bus.app_af_wren, bus.vid_ack, bus.app_af_cmd}, {1'b1, 1'b1, CMD_RD});
        chk("vid_rd_addr", bus.app_af_addr, VA);
        bus.vid_req = 1'b0;
        step();
        chk("vid_ack_pulse", bus.vid_ack, 0);

        // 2: host write, beats A then B, command on the 3rd cycle after grant.
        do_reset(1'b1);
        bus.host_req = 1'b1;
        bus.host_we  = 1'b1;
        exp_q.push_back('{cmd:CMD_WR, addr:HA, host:1'b1});
        step();
        chk("wr_d0", {bus.app_wdf_wren, bus.app_af_wren}, 2'b10);
        chk("wr_d0_data", bus.app_wdf_data, WA);
        chk("wr_mask", bus.app_wdf_mask_data, 0);
        step();
        chk("wr_d1", {bus.app_wdf_wren, bus.app_af_wren}, 2'b10);
        chk("wr_d1_data", bus.app_wdf_data, WB);
        step();
        chk("wr_cmd", {bus.app_af_wren, bus.host_ack, bus.app_wdf_wren, bus.app_af_cmd},
            {1'b1, 1'b1, 1'b0, CMD_WR});
        chk("wr_cmd_addr", bus.app_af_addr, HA);
        bus.host_req = 1'b0;
        step();
        chk("wr_ack_pulse", {bus.host_ack, bus.app_wdf_wren}, 0);

        // 3: both requesters held: V,V,V,V,H twice (host writes need no tags).
        do_reset(1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back('{cmd:CMD_RD, addr:VA, host:1'b0});
            exp_q.push_back('{cmd:CMD_WR, addr:HA, host:1'b1});
        end
        bus.vid_req  = 1'b1;
        bus.host_req = 1'b1;
        bus.host_we  = 1'b1;
        wait_cmds(10, "pattern_done");
        clear_inputs();

        // 4: eight outstanding reads fill the tag FIFO; one burst return frees a slot.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back('{cmd:CMD_RD, addr:VA, host:1'b0});
        bus.vid_req = 1'b1;
        wait_cmds(8, "fill_done");
        for (int i = 0; i < 6; i++) begin
            step();
            chk("full_no_grant", bus.app_af_wren, 0);
        end
        exp_q.push_back('{cmd:CMD_RD, addr:VA, host:1'b0});
        bus.rd_data_valid    = 1'b1;
        bus.rd_data_fifo_out = D0;
        #1;
        chk("full_beat0", {bus.vid_rd_valid, bus.host_rd_valid, bus.rd_data}, {2'b10, D0});
        step();
        bus.rd_data_fifo_out = D1;
        #1;
        chk("full_beat1", {bus.vid_rd_valid, bus.host_rd_valid, bus.rd_data}, {2'b10, D1});
        step();
        bus.rd_data_valid = 1'b0;
        wait_cmds(9, "ninth_granted");
        bus.vid_req = 1'b0;
        step();
        chk("vid_rv_twice", vid_rv_cnt, 2);

        // 5: host read then video read, returns routed by tag (table-driven).
        do_reset(1'b1);
        exp_q.push_back('{cmd:CMD_RD, addr:HA, host:1'b1});
        bus.host_req = 1'b1;
        wait_cmds(1, "host_rd_issued");
        bus.host_req = 1'b0;
        exp_q.push_back('{cmd:CMD_RD, addr:VA, host:1'b0});
        bus.vid_req = 1'b1;
        wait_cmds(2, "vid_rd_issued");
        bus.vid_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.rd_data_valid    = rt[i].vld;
            bus.rd_data_fifo_out = rt[i].dat;
            #1;
            chk($sformatf("ret%0d_vld", i), {bus.vid_rd_valid, bus.host_rd_valid},
                {rt[i].exp_v, rt[i].exp_h});
            chk($sformatf("ret%0d_dat", i), bus.rd_data, rt[i].exp_d);
            step();
        end
        bus.rd_data_valid = 1'b0;

        // 6: eligibility table; each vector starts from reset and the grant is abandoned by the next reset.
        for (int i = 0; i < 8; i++) begin
            do_reset(1'b1);
            bus.phy_init_done = el[i].phy;
            bus.vid_req       = el[i].v;
            bus.host_req      = el[i].h;
            bus.host_we       = el[i].we;
            bus.app_af_afull  = el[i].af;
            bus.app_wdf_afull = el[i].wdf;
            if (el[i].exp == 3'b100) exp_q.push_back('{cmd:CMD_RD, addr:VA, host:1'b0});
            if (el[i].exp == 3'b010) exp_q.push_back('{cmd:CMD_RD, addr:HA, host:1'b1});
            step();
            bus.vid_req       = 1'b0;
            bus.host_req      = 1'b0;
            bus.app_af_afull  = 1'b0;
            bus.app_wdf_afull = 1'b0;
            #1;
            chk($sformatf("elig%0d", i), {bus.vid_ack, bus.host_ack, bus.app_wdf_wren}, el[i].exp);
            step();
        end

        // 7: reset between WR_D0 and WR_D1 abandons the burst.
        do_reset(1'b1);
        bus.host_req = 1'b1;
        bus.host_we  = 1'b1;
        step();
        chk("abort_d0", bus.app_wdf_wren, 1);
        rst = 1'b0;
        #1;
        check_all_zero("abort_now");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_hold", {bus.app_wdf_wren, bus.app_af_wren}, 0);
        end
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_after", {bus.app_wdf_wren, bus.app_af_wren}, 0);
        end
        chk("sb_final", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
